// File: rtl/reservation_station.sv
// reservation_station: holds renamed instructions until both source operands
// are available, snoops the CDB for producer results, and issues one ready
// entry per cycle to the ALU.
// Optional feature macro: RS_OLDEST_FIRST_EN (age-matrix oldest-ready select;
// when undefined the lowest-index ready entry issues).
// Word layouts (MSB first):
//   disp_word: op[7] funct3[3] funct7[7] src1_tag src1_valid src1_data
//              src2_tag src2_valid src2_data imm rd_tag
//   cdb      : tag data
//   iss_word : op funct3 funct7 src1_data src2_data imm tag
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32,
  localparam int RES_W = 17 + 2 * (TAG_W + 1 + XLEN) + XLEN + TAG_W,
  localparam int ALU_W = 17 + 3 * XLEN + TAG_W,
  localparam int CDB_W = TAG_W + XLEN,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [RES_W-1:0] disp_word,
  output logic             disp_ready,
  input  logic             cdb_valid,
  input  logic [CDB_W-1:0] cdb,
  output logic             iss_valid,
  output logic [ALU_W-1:0] iss_word,
  input  logic             iss_ready,
  output logic [CNT_W-1:0] count
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [TAG_W-1:0] src1_tag;
    logic            src1_valid;
    logic [XLEN-1:0] src1_data;
    logic [TAG_W-1:0] src2_tag;
    logic            src2_valid;
    logic [XLEN-1:0] src2_data;
    logic [XLEN-1:0] imm;
    logic [TAG_W-1:0] rd_tag;
  } res_t;

  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] src1_data;
    logic [XLEN-1:0] src2_data;
    logic [XLEN-1:0] imm;
    logic [TAG_W-1:0] tag;
  } alu_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } cdb_t;

  logic [DEPTH-1:0] r_busy;
  res_t             r_entry [DEPTH];
  logic [CNT_W-1:0] r_count;
`ifdef RS_OLDEST_FIRST_EN
  logic [DEPTH-1:0] r_age [DEPTH];
`endif

  res_t             w_disp;
  res_t             w_disp_fwd;
  cdb_t             w_cdb;
  res_t             w_entry_nxt [DEPTH];
  res_t             w_sel;
  alu_t             w_iss;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_alloc_mask;
  logic [DEPTH-1:0] w_free_mask;
  logic [IDXW-1:0]  w_alloc_idx;
  logic [IDXW-1:0]  w_sel_idx;
  logic             w_any_ready;
  logic             w_alloc;
  logic             w_issue;

  assign w_disp      = disp_word;
  assign w_cdb       = cdb;
  assign disp_ready  = ~(&r_busy);
  assign w_alloc     = disp_valid && disp_ready && !flush;
  assign w_any_ready = |w_ready;
  assign iss_valid   = w_any_ready && !flush;
  assign w_issue     = iss_valid && iss_ready;
  assign count       = r_count;
  assign w_sel       = r_entry[w_sel_idx];
  assign iss_word    = w_iss;

  // Lowest-index free slot, per-entry ready bits, and one-hot alloc/free masks.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_alloc_idx = IDXW'(i);
      end else begin
        w_alloc_idx = w_alloc_idx;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i]      = r_busy[i] && r_entry[i].src1_valid && r_entry[i].src2_valid;
      w_alloc_mask[i] = w_alloc && (w_alloc_idx == IDXW'(i));
      w_free_mask[i]  = w_issue && (w_sel_idx == IDXW'(i));
    end
  end

  // Issue select: oldest ready entry (age matrix) or lowest-index ready entry.
  always_comb begin
    w_sel_idx = '0;
`ifdef RS_OLDEST_FIRST_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ready[i] && ((r_age[i] & w_ready) == '0)) begin
        w_sel_idx = IDXW'(i);
      end else begin
        w_sel_idx = w_sel_idx;
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_sel_idx = IDXW'(i);
      end else begin
        w_sel_idx = w_sel_idx;
      end
    end
`endif
  end

  // ALU word from the selected entry; zero when nothing is ready.
  always_comb begin
    w_iss = '0;
    if (w_any_ready) begin
      w_iss.op        = w_sel.op;
      w_iss.funct3    = w_sel.funct3;
      w_iss.funct7    = w_sel.funct7;
      w_iss.src1_data = w_sel.src1_data;
      w_iss.src2_data = w_sel.src2_data;
      w_iss.imm       = w_sel.imm;
      w_iss.tag       = w_sel.rd_tag;
    end else begin
      w_iss = '0;
    end
  end

  // Dispatch-time forwarding: capture a same-cycle CDB result for a pending source.
  always_comb begin
    w_disp_fwd = w_disp;
    if (cdb_valid && !w_disp.src1_valid && (w_disp.src1_tag == w_cdb.tag)) begin
      w_disp_fwd.src1_data  = w_cdb.data;
      w_disp_fwd.src1_valid = 1'b1;
    end else begin
      w_disp_fwd.src1_valid = w_disp.src1_valid;
    end
    if (cdb_valid && !w_disp.src2_valid && (w_disp.src2_tag == w_cdb.tag)) begin
      w_disp_fwd.src2_data  = w_cdb.data;
      w_disp_fwd.src2_valid = 1'b1;
    end else begin
      w_disp_fwd.src2_valid = w_disp.src2_valid;
    end
  end

  // Next entry contents: new allocation, otherwise CDB wakeup of pending sources.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_nxt[i] = r_entry[i];
      if (w_alloc_mask[i]) begin
        w_entry_nxt[i] = w_disp_fwd;
      end else begin
        if (cdb_valid && r_busy[i] && !r_entry[i].src1_valid &&
            (r_entry[i].src1_tag == w_cdb.tag)) begin
          w_entry_nxt[i].src1_data  = w_cdb.data;
          w_entry_nxt[i].src1_valid = 1'b1;
        end else begin
          w_entry_nxt[i].src1_valid = r_entry[i].src1_valid;
        end
        if (cdb_valid && r_busy[i] && !r_entry[i].src2_valid &&
            (r_entry[i].src2_tag == w_cdb.tag)) begin
          w_entry_nxt[i].src2_data  = w_cdb.data;
          w_entry_nxt[i].src2_valid = 1'b1;
        end else begin
          w_entry_nxt[i].src2_valid = r_entry[i].src2_valid;
        end
      end
    end
  end

  // Busy bits and occupancy count; flush empties the station.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy <= (r_busy & ~w_free_mask) | w_alloc_mask;
      case ({w_alloc, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload registers (operand data, valid bits, tags).
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        r_entry[i] <= '0;
      end else begin
        r_entry[i] <= w_entry_nxt[i];
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // Age matrix: row i records entries older than i; freed columns are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n || flush) begin
        r_age[i] <= '0;
      end else if (w_alloc_mask[i]) begin
        r_age[i] <= r_busy & ~w_free_mask;
      end else begin
        r_age[i] <= r_age[i] & ~w_free_mask;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (DEPTH=4, TAG_W=4, XLEN=32).
module tb_reservation_station;

  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         disp_valid;
  logic [126:0] disp_word;
  logic         disp_ready;
  logic         cdb_valid;
  logic [35:0]  cdb;
  logic         iss_valid;
  logic [116:0] iss_word;
  logic         iss_ready;
  logic [2:0]   count;

  int checks;
  int failures;

  reservation_station #(.DEPTH(DEPTH), .TAG_W(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_word(disp_word), .disp_ready(disp_ready),
    .cdb_valid(cdb_valid), .cdb(cdb),
    .iss_valid(iss_valid), .iss_word(iss_word), .iss_ready(iss_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ARITH add: op=0x33, funct3=0, funct7=0, imm=0.
  function automatic logic [126:0] mk(input logic [3:0] t1, input logic v1, input logic [31:0] d1,
                                      input logic [3:0] t2, input logic v2, input logic [31:0] d2,
                                      input logic [3:0] rd);
    return {7'h33, 3'h0, 7'h00, t1, v1, d1, t2, v2, d2, 32'h0, rd};
  endfunction

  function automatic logic [116:0] ax(input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] tg);
    return {7'h33, 3'h0, 7'h00, d1, d2, 32'h0, tg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_word = '0;
    cdb_valid = 1'b0; cdb = '0; iss_ready = 1'b0;
    tick(); tick();
    #1;
    checks++;
    if (disp_ready !== 1'b1 || iss_valid !== 1'b0 || count !== 3'd0 || iss_word !== 117'h0) begin
      failures++;
      $display("FAIL reset got rdy=%b v=%b cnt=%0d w=%h exp rdy=1 v=0 cnt=0 w=0",
               disp_ready, iss_valid, count, iss_word);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    disp_valid = 1'b1; disp_word = mk(4'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd3);
    tick();
    disp_valid = 1'b0; iss_ready = 1'b1;
    #1;
    checks++;
    if (iss_valid !== 1'b1 || iss_word !== ax(32'd5, 32'd7, 4'd3) || count !== 3'd1) begin
      failures++;
      $display("FAIL single_issue got v=%b w=%h cnt=%0d exp v=1 w=%h cnt=1",
               iss_valid, iss_word, count, ax(32'd5, 32'd7, 4'd3));
    end
    tick();
    iss_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got cnt=%0d v=%b exp cnt=0 v=0", count, iss_valid);
    end
  endtask

  task automatic test_wakeup();
    disp_valid = 1'b1; disp_word = mk(4'd2, 1'b0, 32'd0, 4'd0, 1'b1, 32'd9, 4'd5);
    tick();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb = {4'd4, 32'h0000_5555};
    tick();
    cdb = {4'd2, 32'h0000_1234};
    #1;
    checks++;
    if (iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL wakeup_wrong_tag got v=%b exp v=0", iss_valid);
    end
    tick();
    cdb_valid = 1'b0; iss_ready = 1'b1;
    #1;
    checks++;
    if (iss_valid !== 1'b1 || iss_word !== ax(32'h1234, 32'd9, 4'd5)) begin
      failures++;
      $display("FAIL wakeup_issue got v=%b w=%h exp v=1 w=%h", iss_valid, iss_word, ax(32'h1234, 32'd9, 4'd5));
    end
    tick();
    iss_ready = 1'b0;
  endtask

  task automatic test_forward();
    disp_valid = 1'b1; disp_word = mk(4'd0, 1'b1, 32'd1, 4'd6, 1'b0, 32'd0, 4'd7);
    cdb_valid = 1'b1; cdb = {4'd6, 32'h0000_DEAD};
    tick();
    disp_valid = 1'b0; cdb_valid = 1'b0; iss_ready = 1'b1;
    #1;
    checks++;
    if (iss_valid !== 1'b1 || iss_word !== ax(32'd1, 32'hDEAD, 4'd7)) begin
      failures++;
      $display("FAIL forward got v=%b w=%h exp v=1 w=%h", iss_valid, iss_word, ax(32'd1, 32'hDEAD, 4'd7));
    end
    tick();
    iss_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      disp_valid = 1'b1; disp_word = mk(4'd0, 1'b1, 32'(100 + i), 4'd0, 1'b1, 32'd0, 4'(i));
      tick();
    end
    disp_word = mk(4'd0, 1'b1, 32'd200, 4'd0, 1'b1, 32'd0, 4'd9);
    #1;
    checks++;
    if (disp_ready !== 1'b0 || count !== 3'(DEPTH)) begin
      failures++;
      $display("FAIL full got rdy=%b cnt=%0d exp rdy=0 cnt=%0d", disp_ready, count, DEPTH);
    end
    tick();
    iss_ready = 1'b1;
    #1;
    checks++;
    if (iss_valid !== 1'b1 || iss_word !== ax(32'd100, 32'd0, 4'd0) || disp_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_issue got v=%b w=%h rdy=%b exp v=1 w=%h rdy=0",
               iss_valid, iss_word, disp_ready, ax(32'd100, 32'd0, 4'd0));
    end
    tick();
    iss_ready = 1'b0;
    #1;
    checks++;
    if (disp_ready !== 1'b1 || count !== 3'(DEPTH - 1)) begin
      failures++;
      $display("FAIL full_free got rdy=%b cnt=%0d exp rdy=1 cnt=%0d", disp_ready, count, DEPTH - 1);
    end
    tick();
    disp_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'(DEPTH) || disp_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_held_accept got cnt=%0d rdy=%b exp cnt=%0d rdy=0", count, disp_ready, DEPTH);
    end
    iss_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    iss_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL full_drain got cnt=%0d exp cnt=0", count);
    end
  endtask

  task automatic test_ordering();
    logic [3:0] first_tag;
    logic [3:0] second_tag;
`ifdef RS_OLDEST_FIRST_EN
    first_tag = 4'd12; second_tag = 4'd13;
`else
    first_tag = 4'd13; second_tag = 4'd12;
`endif
    disp_valid = 1'b1; disp_word = mk(4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd10);
    tick();
    disp_word = mk(4'd0, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd11);
    tick();
    disp_word = mk(4'd9, 1'b0, 32'd0, 4'd0, 1'b1, 32'd3, 4'd12);
    tick();
    disp_valid = 1'b0; iss_ready = 1'b1;
    tick(); tick();
    iss_ready = 1'b0;
    #1;
    checks++;
    if (iss_valid !== 1'b0 || count !== 3'd1) begin
      failures++;
      $display("FAIL order_setup got v=%b cnt=%0d exp v=0 cnt=1", iss_valid, count);
    end
    disp_valid = 1'b1; disp_word = mk(4'd9, 1'b0, 32'd0, 4'd0, 1'b1, 32'd4, 4'd13);
    tick();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb = {4'd9, 32'h0000_0099};
    tick();
    cdb_valid = 1'b0; iss_ready = 1'b1;
    #1;
    checks++;
    if (iss_valid !== 1'b1 || iss_word[3:0] !== first_tag) begin
      failures++;
      $display("FAIL order_first got v=%b tag=%0d exp v=1 tag=%0d", iss_valid, iss_word[3:0], first_tag);
    end
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_word[3:0] !== second_tag || iss_word[99:68] !== 32'h99) begin
      failures++;
      $display("FAIL order_second got v=%b tag=%0d s1=%h exp v=1 tag=%0d s1=99",
               iss_valid, iss_word[3:0], iss_word[99:68], second_tag);
    end
    tick();
    iss_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    disp_valid = 1'b1; disp_word = mk(4'd0, 1'b1, 32'd20, 4'd0, 1'b1, 32'd0, 4'd4);
    tick();
    iss_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) disp_word = mk(4'd0, 1'b1, 32'(21 + i), 4'd0, 1'b1, 32'd0, 4'(5 + i));
      else disp_valid = 1'b0;
      #1;
      checks++;
      if (iss_valid !== 1'b1 || iss_word !== ax(32'(20 + i), 32'd0, 4'(4 + i)) || count !== 3'd1) begin
        failures++;
        $display("FAIL b2b_%0d got v=%b w=%h cnt=%0d exp v=1 w=%h cnt=1",
                 i, iss_valid, iss_word, count, ax(32'(20 + i), 32'd0, 4'(4 + i)));
      end
      tick();
    end
    iss_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL b2b_drain got cnt=%0d exp cnt=0", count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      disp_valid = 1'b1; disp_word = mk(4'd0, 1'b1, 32'(i), 4'd0, 1'b1, 32'd0, 4'(1 + i));
      tick();
    end
    disp_word = mk(4'd0, 1'b1, 32'd77, 4'd0, 1'b1, 32'd0, 4'd14);
    flush = 1'b1; iss_ready = 1'b1;
    #1;
    checks++;
    if (iss_valid !== 1'b0 || count !== 3'd3) begin
      failures++;
      $display("FAIL flush_cycle got v=%b cnt=%0d exp v=0 cnt=3", iss_valid, count);
    end
    tick();
    flush = 1'b0; disp_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_after got cnt=%0d v=%b rdy=%b exp cnt=0 v=0 rdy=1", count, iss_valid, disp_ready);
    end
    iss_ready = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_wakeup();
    test_forward();
    test_full();
    test_ordering();
    test_back_to_back();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
